// File: rtl/arp_rx_cache_pkg.sv
// Shared constants, types and the ARP field check for the receive classifier.
package arp_rx_cache_pkg;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] ARP_HTYPE     = 16'h0001;
  localparam logic [15:0] ARP_PTYPE     = 16'h0800;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;
  localparam logic [15:0] ARP_OPER_REQ  = 16'h0001;
  localparam logic [15:0] ARP_OPER_REP  = 16'h0002;

  localparam logic [5:0]  HDR_LAST  = 6'd13;
  localparam logic [5:0]  ARP_FIRST = 6'd14;
  localparam logic [5:0]  ARP_LAST  = 6'd41;

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_REPLAY = 3'd1,
    ST_PASS   = 3'd2,
    ST_ARP    = 3'd3,
    ST_DROP   = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [47:0] mac;
  } arp_entry_t;

  function automatic logic arp_fields_ok(
    input logic [15:0] htype,
    input logic [15:0] ptype,
    input logic [7:0]  hlen,
    input logic [7:0]  plen,
    input logic [15:0] oper,
    input logic [31:0] tpa,
    input logic [31:0] our_ip
  );
    return (htype == ARP_HTYPE) && (ptype == ARP_PTYPE) &&
           (hlen == ARP_HLEN) && (plen == ARP_PLEN) &&
           ((oper == ARP_OPER_REQ) || (oper == ARP_OPER_REP)) &&
           (tpa == our_ip);
  endfunction

endpackage

// File: rtl/arp_rx_cache_cache.sv
// Fully-associative IP->MAC table with in-place update, round-robin eviction
// and a registered single-cycle lookup port.
module arp_rx_cache_cache
  import arp_rx_cache_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_ip,
  input  logic [47:0] wr_mac,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_valid,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac
);

  localparam int PW = $clog2(DEPTH);

  arp_entry_t       tbl_r [DEPTH];
  logic [PW-1:0]    ptr_r;
  logic             match_s;
  logic [PW-1:0]    match_idx_s;
  logic             hit_s;
  logic [47:0]      hit_mac_s;

  // Compare the write and lookup addresses against every live entry; IPs are unique so OR-merge is safe.
  always_comb begin
    match_s     = 1'b0;
    match_idx_s = '0;
    hit_s       = 1'b0;
    hit_mac_s   = 48'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl_r[i].valid && (tbl_r[i].ip == wr_ip)) begin
        match_s     = 1'b1;
        match_idx_s = PW'(i);
      end else begin
        match_s     = match_s;
      end
      if (tbl_r[i].valid && (tbl_r[i].ip == lookup_ip)) begin
        hit_s     = 1'b1;
        hit_mac_s = hit_mac_s | tbl_r[i].mac;
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Table update and lookup result register; lookups see the table before this cycle's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_r[i] <= '0;
      end
      ptr_r        <= '0;
      lookup_valid <= 1'b0;
      lookup_hit   <= 1'b0;
      lookup_mac   <= 48'h0;
    end else begin
      lookup_valid <= lookup_req;
      lookup_hit   <= lookup_req && hit_s;
      lookup_mac   <= (lookup_req && hit_s) ? hit_mac_s : 48'h0;
      if (wr_en) begin
        if (match_s) begin
          tbl_r[match_idx_s].mac <= wr_mac;
        end else begin
          tbl_r[ptr_r] <= {1'b1, wr_ip, wr_mac};
          ptr_r        <= ptr_r + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/arp_rx_cache.sv
// Receive classifier: parses ARP for local_ip into the cache and reply event,
// forwards every other frame byte-exact on the udp stream.
module arp_rx_cache
  import arp_rx_cache_pkg::*;
#(
  parameter logic [47:0] local_mac   = 48'h00_0a_35_01_02_03,
  parameter logic [31:0] local_ip    = 32'h10_00_00_80,
  parameter int          CACHE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_fifo_tvalid,
  output logic        rx_fifo_tready,
  input  logic [7:0]  rx_fifo_tdata,
  input  logic        rx_fifo_tlast,
  input  logic        rx_fifo_tuser,
  output logic        dv_out,
  output logic [47:0] remote_mac,
  output logic [31:0] remote_ip,
  output logic        udp_tvalid,
  input  logic        udp_tready,
  output logic [7:0]  udp_tdata,
  output logic        udp_tlast,
  output logic        udp_tuser,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_valid,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac
);

  rx_state_t   state_r, state_s;
  logic [5:0]  cnt_r;
  logic [7:0]  hdr_r [16];
  logic [15:0] htype_r, ptype_r, oper_r;
  logic [7:0]  hlen_r, plen_r;
  logic [47:0] sha_r;
  logic [31:0] spa_r;
  logic [23:0] tpa_r;
  logic        commit_r;
  logic        rx_ready_s, rx_acc_s, is_arp_s, fields_ok_s, arp_accept_s, cache_we_s;

  assign rx_fifo_tready = rx_ready_s && !rst;
  assign rx_acc_s       = rx_fifo_tvalid && rx_fifo_tready;
  assign is_arp_s       = ({hdr_r[12], rx_fifo_tdata} == ETHERTYPE_ARP);
  // The last TPA byte is still on the bus when byte 41 is checked.
  assign fields_ok_s    = arp_fields_ok(htype_r, ptype_r, hlen_r, plen_r, oper_r,
                                        {tpa_r, rx_fifo_tdata}, local_ip);
  assign arp_accept_s   = rx_acc_s && (state_r == ST_ARP) && rx_fifo_tlast && !rx_fifo_tuser &&
                          (((cnt_r == ARP_LAST) && fields_ok_s) || (cnt_r > ARP_LAST));
  assign cache_we_s     = commit_r && (spa_r != 32'h0);

  // Frame parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (rx_acc_s && !rx_fifo_tlast && (cnt_r == HDR_LAST)) begin
          state_s = is_arp_s ? ST_ARP : ST_REPLAY;
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_REPLAY: begin
        if (udp_tready && (cnt_r == HDR_LAST)) begin
          state_s = ST_PASS;
        end else begin
          state_s = ST_REPLAY;
        end
      end
      ST_PASS: begin
        if (rx_acc_s && rx_fifo_tlast) begin
          state_s = ST_HDR;
        end else begin
          state_s = ST_PASS;
        end
      end
      ST_ARP: begin
        if (rx_acc_s && rx_fifo_tlast) begin
          state_s = ST_HDR;
        end else if (rx_acc_s && (cnt_r == ARP_LAST) && !fields_ok_s) begin
          state_s = ST_DROP;
        end else begin
          state_s = ST_ARP;
        end
      end
      ST_DROP: begin
        if (rx_acc_s && rx_fifo_tlast) begin
          state_s = ST_HDR;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: state_s = ST_HDR;
    endcase
  end

  // Stream outputs: header replay from the buffer, then cut-through.
  always_comb begin
    rx_ready_s = 1'b0;
    udp_tvalid = 1'b0;
    udp_tdata  = 8'h00;
    udp_tlast  = 1'b0;
    udp_tuser  = 1'b0;
    case (state_r)
      ST_HDR, ST_ARP, ST_DROP: rx_ready_s = 1'b1;
      ST_REPLAY: begin
        udp_tvalid = 1'b1;
        udp_tdata  = hdr_r[cnt_r[3:0]];
      end
      ST_PASS: begin
        rx_ready_s = udp_tready;
        udp_tvalid = rx_fifo_tvalid;
        udp_tdata  = rx_fifo_tdata;
        udp_tlast  = rx_fifo_tlast;
        udp_tuser  = rx_fifo_tlast && rx_fifo_tuser;
      end
      default: rx_ready_s = 1'b0;
    endcase
  end

  // Byte counter, header buffer and ARP field capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        hdr_r[i] <= 8'h00;
      end
      htype_r <= 16'h0;
      ptype_r <= 16'h0;
      oper_r  <= 16'h0;
      hlen_r  <= 8'h0;
      plen_r  <= 8'h0;
      sha_r   <= 48'h0;
      spa_r   <= 32'h0;
      tpa_r   <= 24'h0;
    end else begin
      case (state_r)
        ST_HDR: begin
          if (rx_acc_s) begin
            hdr_r[cnt_r[3:0]] <= rx_fifo_tdata;
            if (rx_fifo_tlast) begin
              cnt_r <= 6'd0;
            end else if (cnt_r == HDR_LAST) begin
              cnt_r <= is_arp_s ? ARP_FIRST : 6'd0;
            end else begin
              cnt_r <= cnt_r + 6'd1;
            end
          end
        end
        ST_REPLAY: begin
          if (udp_tready) begin
            cnt_r <= (cnt_r == HDR_LAST) ? 6'd0 : cnt_r + 6'd1;
          end
        end
        ST_ARP: begin
          if (rx_acc_s) begin
            if (rx_fifo_tlast) begin
              cnt_r <= 6'd0;
            end else if (cnt_r <= ARP_LAST) begin
              cnt_r <= cnt_r + 6'd1;
            end
            case (cnt_r)
              6'd14: htype_r[15:8] <= rx_fifo_tdata;
              6'd15: htype_r[7:0]  <= rx_fifo_tdata;
              6'd16: ptype_r[15:8] <= rx_fifo_tdata;
              6'd17: ptype_r[7:0]  <= rx_fifo_tdata;
              6'd18: hlen_r        <= rx_fifo_tdata;
              6'd19: plen_r        <= rx_fifo_tdata;
              6'd20: oper_r[15:8]  <= rx_fifo_tdata;
              6'd21: oper_r[7:0]   <= rx_fifo_tdata;
              6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27: sha_r <= {sha_r[39:0], rx_fifo_tdata};
              6'd28, 6'd29, 6'd30, 6'd31: spa_r <= {spa_r[23:0], rx_fifo_tdata};
              6'd38, 6'd39, 6'd40: tpa_r <= {tpa_r[15:0], rx_fifo_tdata};
              default: tpa_r <= tpa_r;
            endcase
          end
        end
        ST_DROP: begin
          if (rx_acc_s && rx_fifo_tlast) begin
            cnt_r <= 6'd0;
          end
        end
        default: cnt_r <= 6'd0;
      endcase
    end
  end

  // Commit of an accepted ARP frame: reply event now, cache write strobe for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_r   <= 1'b0;
      dv_out     <= 1'b0;
      remote_mac <= 48'h0;
      remote_ip  <= 32'h0;
    end else begin
      commit_r <= arp_accept_s;
      dv_out   <= arp_accept_s && (oper_r == ARP_OPER_REQ);
      if (arp_accept_s && (oper_r == ARP_OPER_REQ)) begin
        remote_mac <= sha_r;
        remote_ip  <= spa_r;
      end
    end
  end

  arp_rx_cache_cache #(.DEPTH(CACHE_DEPTH)) u_cache (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (cache_we_s),
    .wr_ip        (spa_r),
    .wr_mac       (sha_r),
    .lookup_req   (lookup_req),
    .lookup_ip    (lookup_ip),
    .lookup_valid (lookup_valid),
    .lookup_hit   (lookup_hit),
    .lookup_mac   (lookup_mac)
  );

endmodule

// File: tb/tb_arp_rx_cache.sv
// Directed bench for arp_rx_cache: table of ARP frames with expected events and
// lookups, plus hand sequences for UDP forwarding, lookup pipelining and mid-frame reset.
module tb_arp_rx_cache;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    logic        tu;
    int          len;
    int          exp_dv;
    logic [31:0] chk_ip;
    logic        chk_hit;
    logic [47:0] chk_mac;
  } vec_t;

  typedef struct {
    logic [31:0] ip;
    logic        hit;
    logic [47:0] mac;
  } lk_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_fifo_tvalid = 1'b0;
  logic        rx_fifo_tready;
  logic [7:0]  rx_fifo_tdata = 8'h00;
  logic        rx_fifo_tlast = 1'b0;
  logic        rx_fifo_tuser = 1'b0;
  logic        dv_out;
  logic [47:0] remote_mac;
  logic [31:0] remote_ip;
  logic        udp_tvalid;
  logic        udp_tready = 1'b1;
  logic [7:0]  udp_tdata;
  logic        udp_tlast;
  logic        udp_tuser;
  logic        lookup_req = 1'b0;
  logic [31:0] lookup_ip = 32'h0;
  logic        lookup_valid;
  logic        lookup_hit;
  logic [47:0] lookup_mac;

  int          total = 0;
  int          bad = 0;
  int          dv_cnt = 0;
  logic        rand_ready = 1'b0;
  logic [9:0]  udp_q[$];

  arp_rx_cache dut (
    .clk(clk), .rst(rst),
    .rx_fifo_tvalid(rx_fifo_tvalid), .rx_fifo_tready(rx_fifo_tready),
    .rx_fifo_tdata(rx_fifo_tdata), .rx_fifo_tlast(rx_fifo_tlast), .rx_fifo_tuser(rx_fifo_tuser),
    .dv_out(dv_out), .remote_mac(remote_mac), .remote_ip(remote_ip),
    .udp_tvalid(udp_tvalid), .udp_tready(udp_tready), .udp_tdata(udp_tdata),
    .udp_tlast(udp_tlast), .udp_tuser(udp_tuser),
    .lookup_req(lookup_req), .lookup_ip(lookup_ip),
    .lookup_valid(lookup_valid), .lookup_hit(lookup_hit), .lookup_mac(lookup_mac)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    udp_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (dv_out) dv_cnt++;
    if (udp_tvalid && udp_tready) udp_q.push_back({udp_tuser, udp_tlast, udp_tdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bq_t eth(input logic [15:0] et);
    bq_t f;
    logic [47:0] src;
    src = 48'h94103eb7e201;
    for (int i = 0; i < 6; i++) f.push_back(8'hff);
    for (int i = 0; i < 6; i++) f.push_back(src[47-8*i -: 8]);
    f.push_back(et[15:8]);
    f.push_back(et[7:0]);
    return f;
  endfunction

  function automatic bq_t arp_frame(input logic [15:0] oper, input logic [47:0] sha,
                                    input logic [31:0] spa, input logic [31:0] tpa);
    bq_t f;
    f = eth(16'h0806);
    f.push_back(8'h00); f.push_back(8'h01); f.push_back(8'h08); f.push_back(8'h00);
    f.push_back(8'h06); f.push_back(8'h04);
    f.push_back(oper[15:8]); f.push_back(oper[7:0]);
    for (int i = 0; i < 6; i++) f.push_back(sha[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) f.push_back(spa[31-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'h00);
    for (int i = 0; i < 4; i++) f.push_back(tpa[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) f.push_back(8'h00);
    return f;
  endfunction

  function automatic bq_t udp_frame(input int n);
    bq_t f;
    f = eth(16'h0800);
    for (int i = 14; i < n; i++) f.push_back(8'(i * 7 + 3));
    return f;
  endfunction

  task automatic send(input bq_t f, input logic tu, input logic with_last);
    int g;
    int w;
    for (int i = 0; i < f.size(); i++) begin
      g = int'($urandom_range(0, 2));
      repeat (g) begin
        rx_fifo_tvalid = 1'b0;
        rx_fifo_tlast  = 1'b0;
        rx_fifo_tuser  = 1'b0;
        @(posedge clk); #1;
      end
      rx_fifo_tvalid = 1'b1;
      rx_fifo_tdata  = f[i];
      rx_fifo_tlast  = with_last && (i == f.size() - 1);
      rx_fifo_tuser  = tu && rx_fifo_tlast;
      w = 0;
      @(negedge clk);
      while (!rx_fifo_tready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: byte %0d never accepted, got tready=0 required 1", i);
      end
      @(posedge clk); #1;
    end
    rx_fifo_tvalid = 1'b0;
    rx_fifo_tlast  = 1'b0;
    rx_fifo_tuser  = 1'b0;
  endtask

  task automatic lookup(input string nm, input logic [31:0] ip, input logic hit, input logic [47:0] mac);
    lookup_req = 1'b1;
    lookup_ip  = ip;
    @(posedge clk); #1;
    lookup_req = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(lookup_valid), 64'(1'b1));
    chk({nm, "_hit"}, 64'(lookup_hit), 64'(hit));
    chk({nm, "_mac"}, 64'(lookup_mac), 64'(mac));
    @(posedge clk); #1;
  endtask

  task automatic check_udp(input string nm, input bq_t f, input logic tu);
    int errs;
    logic [9:0] e;
    errs = 0;
    chk({nm, "_len"}, 64'(udp_q.size()), 64'(f.size()));
    for (int i = 0; i < f.size() && i < udp_q.size(); i++) begin
      e = {tu && (i == f.size() - 1), i == f.size() - 1, f[i]};
      if (udp_q[i] !== e) errs++;
    end
    chk({nm, "_bytes"}, 64'(errs), 64'(0));
  endtask

  initial begin
    vec_t vecs[$];
    lk_t  lks[$];
    bq_t  f;
    bq_t  g;
    int   dv0;
    int   w;

    vecs.push_back('{16'h0001, 48'h94103eb7e201, 32'h100000c8, 32'h10000080, 1'b0, 46, 1, 32'h100000c8, 1'b1, 48'h94103eb7e201});
    vecs.push_back('{16'h0001, 48'h111111111111, 32'h10000063, 32'h10000081, 1'b0, 46, 0, 32'h10000063, 1'b0, 48'h0});
    vecs.push_back('{16'h0001, 48'h111111111111, 32'h10000063, 32'h10000080, 1'b1, 46, 0, 32'h10000063, 1'b0, 48'h0});
    vecs.push_back('{16'h0001, 48'h111111111111, 32'h10000063, 32'h10000080, 1'b0, 31, 0, 32'h10000063, 1'b0, 48'h0});
    for (int k = 1; k <= 9; k++)
      vecs.push_back('{16'h0002, 48'h020000000000 | 48'(k), 32'h10000000 | 32'(k), 32'h10000080, 1'b0, 46, 0,
                       32'h10000000 | 32'(k), 1'b1, 48'h020000000000 | 48'(k)});
    vecs.push_back('{16'h0002, 48'h0a0b0c0d0e05, 32'h10000005, 32'h10000080, 1'b0, 46, 0, 32'h10000005, 1'b1, 48'h0a0b0c0d0e05});
    vecs.push_back('{16'h0002, 48'h02000000000a, 32'h1000000a, 32'h10000080, 1'b0, 46, 0, 32'h10000002, 1'b0, 48'h0});
    vecs.push_back('{16'h0001, 48'h94103eb7e201, 32'h100000c8, 32'h10000080, 1'b0, 10, 0, 32'h10000063, 1'b0, 48'h0});
    vecs.push_back('{16'h0001, 48'h123456789abc, 32'h00000000, 32'h10000080, 1'b0, 46, 1, 32'h00000000, 1'b0, 48'h0});
    vecs.push_back('{16'h0001, 48'h94103eb7e201, 32'h100000c8, 32'h10000080, 1'b0, 46, 1, 32'h100000c8, 1'b1, 48'h94103eb7e201});

    lks.push_back('{32'h10000001, 1'b0, 48'h0});
    lks.push_back('{32'h10000002, 1'b0, 48'h0});
    lks.push_back('{32'h10000003, 1'b0, 48'h0});
    lks.push_back('{32'h10000004, 1'b1, 48'h020000000004});
    lks.push_back('{32'h10000005, 1'b1, 48'h0a0b0c0d0e05});
    lks.push_back('{32'h10000006, 1'b1, 48'h020000000006});
    lks.push_back('{32'h10000009, 1'b1, 48'h020000000009});
    lks.push_back('{32'h1000000a, 1'b1, 48'h02000000000a});
    lks.push_back('{32'h100000c8, 1'b1, 48'h94103eb7e201});
    lks.push_back('{32'h10000063, 1'b0, 48'h0});

    repeat (3) @(negedge clk);
    chk("tready_in_reset", 64'(rx_fifo_tready), 64'(1'b0));
    chk("dv_reset", 64'(dv_out), 64'(1'b0));
    chk("remote_mac_reset", 64'(remote_mac), 64'(48'h0));
    chk("lookup_valid_reset", 64'(lookup_valid), 64'(1'b0));
    chk("udp_tvalid_reset", 64'(udp_tvalid), 64'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_reset", 64'(rx_fifo_tready), 64'(1'b1));
    @(posedge clk); #1;

    for (int v = 0; v < vecs.size(); v++) begin
      f = arp_frame(vecs[v].oper, vecs[v].sha, vecs[v].spa, vecs[v].tpa);
      while (f.size() > vecs[v].len) void'(f.pop_back());
      dv0 = dv_cnt;
      udp_q.delete();
      send(f, vecs[v].tu, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      chk($sformatf("v%0d_dv", v), 64'(dv_cnt - dv0), 64'(vecs[v].exp_dv));
      chk($sformatf("v%0d_no_udp", v), 64'(udp_q.size()), 64'(0));
      if (vecs[v].exp_dv == 1) begin
        chk($sformatf("v%0d_remote_mac", v), 64'(remote_mac), 64'(vecs[v].sha));
        chk($sformatf("v%0d_remote_ip", v), 64'(remote_ip), 64'(vecs[v].spa));
      end
      lookup($sformatf("v%0d_lk", v), vecs[v].chk_ip, vecs[v].chk_hit, vecs[v].chk_mac);
    end

    for (int i = 0; i < lks.size(); i++)
      lookup($sformatf("lk%0d", i), lks[i].ip, lks[i].hit, lks[i].mac);

    // Back-to-back lookups, one per cycle.
    lookup_req = 1'b1; lookup_ip = 32'h10000004;
    @(posedge clk); #1; lookup_ip = 32'h10000001;
    @(negedge clk);
    chk("b2b0_mac", 64'(lookup_mac), 64'(48'h020000000004));
    @(posedge clk); #1; lookup_ip = 32'h10000009;
    @(negedge clk);
    chk("b2b1_hit", 64'(lookup_hit), 64'(1'b0));
    chk("b2b1_valid", 64'(lookup_valid), 64'(1'b1));
    @(posedge clk); #1; lookup_req = 1'b0;
    @(negedge clk);
    chk("b2b2_mac", 64'(lookup_mac), 64'(48'h020000000009));
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_valid_drop", 64'(lookup_valid), 64'(1'b0));
    @(posedge clk); #1;

    // UDP forwarding with steady and random backpressure, then tuser propagation.
    for (int m = 0; m < 2; m++) begin
      rand_ready = (m == 1);
      f = udp_frame(50);
      dv0 = dv_cnt;
      udp_q.delete();
      send(f, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      check_udp($sformatf("udp%0d", m), f, 1'b0);
      chk($sformatf("udp%0d_no_dv", m), 64'(dv_cnt - dv0), 64'(0));
    end
    rand_ready = 1'b0;
    f = udp_frame(20);
    udp_q.delete();
    send(f, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check_udp("udp_tuser", f, 1'b1);
    lookup("after_udp", 32'h100000c8, 1'b1, 48'h94103eb7e201);

    // Reset in the middle of a forwarded frame.
    f = udp_frame(50);
    g.delete();
    for (int i = 0; i < 20; i++) g.push_back(f[i]);
    send(g, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_tready", 64'(rx_fifo_tready), 64'(1'b0));
    chk("midrst_remote_mac", 64'(remote_mac), 64'(48'h0));
    chk("midrst_remote_ip", 64'(remote_ip), 64'(32'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    lookup("midrst_cleared", 32'h100000c8, 1'b0, 48'h0);
    udp_q.delete();
    dv0 = dv_cnt;
    f = arp_frame(16'h0001, 48'h94103eb7e201, 32'h100000c8, 32'h10000080);
    fork
      send(f, 1'b0, 1'b1);
      begin
        w = 0;
        @(negedge clk);
        while (!dv_out && w < 500) begin
          @(negedge clk);
          w++;
        end
        chk("post_rst_dv_seen", 64'(w < 500), 64'(1'b1));
        lookup_req = 1'b1;
        lookup_ip  = 32'h100000c8;
        @(posedge clk); #1;
        lookup_req = 1'b0;
        @(negedge clk);
        chk("same_cycle_valid", 64'(lookup_valid), 64'(1'b1));
        chk("same_cycle_old_hit", 64'(lookup_hit), 64'(1'b0));
        chk("same_cycle_old_mac", 64'(lookup_mac), 64'(48'h0));
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_dv_count", 64'(dv_cnt - dv0), 64'(1));
    chk("post_rst_remote_ip", 64'(remote_ip), 64'(32'h100000c8));
    chk("post_rst_no_udp", 64'(udp_q.size()), 64'(0));
    lookup("post_rst_learned", 32'h100000c8, 1'b1, 48'h94103eb7e201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
